// File: rtl/sha256_compress_if.sv
// Block-in / digest-out bundle for the SHA-256 compression engine.
interface sha256_compress_if;
  logic         block_valid;
  logic         block_ready;
  logic [0:511] block;
  logic         block_first;
  logic         block_last;
  logic         digest_valid;
  logic [0:255] digest;
  logic         busy;

  modport master (
    output block_valid, block, block_first, block_last,
    input  block_ready, digest_valid, digest, busy
  );

  modport slave (
    input  block_valid, block, block_first, block_last,
    output block_ready, digest_valid, digest, busy
  );
endinterface

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: one round per clock, chains H across blocks,
// 66-cycle block period (accept, 64 rounds, H update).
module sha256_compress (
  input  logic               clk,
  input  logic               reset,
  sha256_compress_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE} state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t      state, state_nxt;
  logic [31:0] h_reg [8];   // chained hash H0..H7
  logic [31:0] wv    [8];   // working variables a..h
  logic [31:0] win   [16];  // message schedule window, win[0] = Wt
  logic [5:0]  t;
  logic        last_q, dv_q, busy_q;
  logic        accept;
  logic [31:0] t1, t2, w_new;

  assign accept = bus.block_valid && bus.block_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (t == 6'd63) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is decoded from state and held low while reset is asserted
  always_comb begin
    bus.block_ready = (state == IDLE) && !reset;
  end

  // Round function and next schedule word
  always_comb begin
    t1 = wv[7] + (rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25))
       + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[t] + win[0];
    t2 = (rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22))
       + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
    w_new = (rotr(win[14], 17) ^ rotr(win[14], 19) ^ (win[14] >> 10)) + win[9]
          + (rotr(win[1], 7) ^ rotr(win[1], 18) ^ (win[1] >> 3)) + win[0];
  end

  // Datapath: block load, round shift, hash update, status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) begin
        h_reg[i] <= IV[i];
        wv[i]    <= '0;
      end
      for (int unsigned i = 0; i < 16; i++) win[i] <= '0;
      t      <= '0;
      last_q <= 1'b0;
      dv_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      busy_q <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            for (int unsigned i = 0; i < 16; i++) win[i] <= bus.block[32*i +: 32];
            last_q <= bus.block_last;
            t      <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
              if (bus.block_first) begin
                h_reg[i] <= IV[i];
                wv[i]    <= IV[i];
              end else begin
                wv[i]    <= h_reg[i];
              end
            end
          end
        end
        ROUND: begin
          wv[0] <= t1 + t2;
          wv[1] <= wv[0];
          wv[2] <= wv[1];
          wv[3] <= wv[2];
          wv[4] <= wv[3] + t1;
          wv[5] <= wv[4];
          wv[6] <= wv[5];
          wv[7] <= wv[6];
          for (int unsigned i = 0; i < 15; i++) win[i] <= win[i+1];
          win[15] <= w_new;
          t <= t + 6'd1;
        end
        UPDATE: begin
          for (int unsigned i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + wv[i];
          dv_q <= last_q;
        end
        default: ;
      endcase
    end
  end

  // Registered status and digest straight from the H registers
  always_comb begin
    bus.digest_valid = dv_q;
    bus.busy         = busy_q;
    for (int unsigned i = 0; i < 8; i++) bus.digest[32*i +: 32] = h_reg[i];
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: known-answer vectors, timing,
// backpressure, mid-operation reset and randomized chained blocks.
module tb_sha256_compress;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_acc = -1000;
  int   prev_acc = -1000;
  logic [0:255] mh;

  sha256_compress_if bus ();

  sha256_compress dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [255:0] IV_D    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] ABC_B   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Reference: full 64-word schedule, then 64 rounds, then add-back
  function automatic logic [0:255] ref_compress(input logic [0:255] hin, input logic [0:511] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
    logic [0:255] hout;
    for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    a = hin[0:31];    b = hin[32:63];   c = hin[64:95];   d = hin[96:127];
    e = hin[128:159]; f = hin[160:191]; g = hin[192:223]; h = hin[224:255];
    for (int i = 0; i < 64; i++) begin
      x1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
      x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
    end
    hout = {hin[0:31] + a, hin[32:63] + b, hin[64:95] + c, hin[96:127] + d,
            hin[128:159] + e, hin[160:191] + f, hin[192:223] + g, hin[224:255] + h};
    return hout;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one block, then checks every cycle of its 66-cycle period.
  // With hold set, valid stays high and data churns while the engine is busy.
  task automatic run_block(input logic [0:511] blk, input logic first, input logic last,
                           input bit hold, input string tag);
    int  n;
    bit  ok_ready, ok_busy, ok_dv;
    bus.block       = blk;
    bus.block_first = first;
    bus.block_last  = last;
    bus.block_valid = 1'b1;
    n = 0;
    while (!bus.block_ready && n < 200) begin
      step();
      n++;
    end
    check({tag, "_ready_wait"}, {255'h0, bus.block_ready}, 256'h1);
    prev_acc = last_acc;
    last_acc = cyc;
    if (first) mh = IV_D;
    mh = ref_compress(mh, blk);
    step();
    if (!hold) bus.block_valid = 1'b0;
    ok_ready = 1; ok_busy = 1; ok_dv = 1;
    for (int k = 1; k <= 65; k++) begin
      if (bus.block_ready !== 1'b0) ok_ready = 0;
      if (bus.busy !== 1'b1) ok_busy = 0;
      if (bus.digest_valid !== 1'b0) ok_dv = 0;
      if (hold) begin
        bus.block       = {16{$urandom}};
        bus.block_first = 1'($urandom_range(0, 1));
        bus.block_last  = 1'($urandom_range(0, 1));
      end
      step();
    end
    check({tag, "_ready_low_while_busy"}, {255'h0, ok_ready}, 256'h1);
    check({tag, "_busy_high"}, {255'h0, ok_busy}, 256'h1);
    check({tag, "_no_early_digest_valid"}, {255'h0, ok_dv}, 256'h1);
    check({tag, "_ready_at_66"}, {255'h0, bus.block_ready}, 256'h1);
    check({tag, "_busy_clear_at_66"}, {255'h0, bus.busy}, 256'h0);
    check({tag, "_digest_valid_at_66"}, {255'h0, bus.digest_valid}, {255'h0, last});
    if (last) check({tag, "_digest_model"}, bus.digest, mh);
  endtask

  initial begin
    bit ok_dv;
    logic [0:511] rblk;
    logic rfirst, rlast;
    reset = 1'b1;
    bus.block_valid = 1'b0;
    bus.block       = '0;
    bus.block_first = 1'b0;
    bus.block_last  = 1'b0;
    mh = IV_D;

    step();
    step();
    check("ready_in_reset", {255'h0, bus.block_ready}, 256'h0);
    reset = 1'b0;
    step();
    check("reset_ready", {255'h0, bus.block_ready}, 256'h1);
    check("reset_busy", {255'h0, bus.busy}, 256'h0);
    check("reset_digest_valid", {255'h0, bus.digest_valid}, 256'h0);
    check("reset_digest_iv", bus.digest, IV_D);

    run_block(ABC_B, 1'b1, 1'b1, 1'b0, "abc");
    check("abc_known", bus.digest, ABC_D);

    run_block(EMPTY_B, 1'b1, 1'b1, 1'b0, "empty_after_abc");
    check("empty_known", bus.digest, EMPTY_D);

    run_block(TWO_B1, 1'b1, 1'b0, 1'b0, "two_blk1");
    run_block(TWO_B2, 1'b0, 1'b1, 1'b0, "two_blk2");
    check("two_block_known", bus.digest, TWO_D);

    run_block(ABC_B, 1'b1, 1'b1, 1'b1, "bp_abc1");
    check("bp_abc1_known", bus.digest, ABC_D);
    run_block(ABC_B, 1'b1, 1'b1, 1'b0, "bp_abc2");
    check("bp_accept_spacing", 256'(last_acc - prev_acc), 256'd66);
    check("bp_abc2_known", bus.digest, ABC_D);

    // Mid-operation reset during round 30
    bus.block = ABC_B; bus.block_first = 1'b1; bus.block_last = 1'b1; bus.block_valid = 1'b1;
    while (!bus.block_ready) step();
    step();
    bus.block_valid = 1'b0;
    for (int k = 1; k < 31; k++) step();
    reset = 1'b1;
    step();
    check("abort_dv_in_reset", {255'h0, bus.digest_valid}, 256'h0);
    check("abort_busy_in_reset", {255'h0, bus.busy}, 256'h0);
    reset = 1'b0;
    step();
    check("abort_busy_after", {255'h0, bus.busy}, 256'h0);
    check("abort_ready_after", {255'h0, bus.block_ready}, 256'h1);
    check("abort_digest_iv", bus.digest, IV_D);
    mh = IV_D;
    ok_dv = 1;
    for (int k = 0; k < 70; k++) begin
      if (bus.digest_valid !== 1'b0) ok_dv = 0;
      step();
    end
    check("abort_no_digest_valid", {255'h0, ok_dv}, 256'h1);
    run_block(ABC_B, 1'b1, 1'b1, 1'b0, "abort_resend");
    check("abort_resend_known", bus.digest, ABC_D);

    // Randomized blocks, including non-first blocks chaining off whatever H holds
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 16; j++) rblk[32*j +: 32] = $urandom;
      rfirst = (r == 0) || ($urandom_range(0, 2) == 0);
      rlast  = (r == 7) || ($urandom_range(0, 1) == 1);
      run_block(rblk, rfirst, rlast, ($urandom_range(0, 1) == 1), $sformatf("rand%0d", r));
    end
    bus.block_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
